// File: rtl/dither_rgb1.sv
// Two-stage 8-bit to 1-bit-per-channel error-diffusion dither with aligned sync/enable/frame.
// Optional DITHER_TEMPORAL_EN: a 2-bit frame counter rotates the per-line seed each frame.
module dither_rgb1 #(
  parameter bit         H_POL = 1'b0,
  parameter bit         V_POL = 1'b0,
  parameter logic [7:0] SEED  = 8'd128
) (
  input  logic       i_pix_clk,
  input  logic       i_rst,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic       i_de,
  input  logic       i_frame,
  input  logic [7:0] i_red,
  input  logic [7:0] i_green,
  input  logic [7:0] i_blue,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_de,
  output logic       o_frame,
  output logic       o_red,
  output logic       o_green,
  output logic       o_blue
);

  logic       hs_p1, vs_p1, vld_p1, frame_p1;
  logic [7:0] red_p1, green_p1, blue_p1;
  logic [7:0] err_r, err_g, err_b;
  logic [7:0] seed;
  logic [8:0] sum_r, sum_g, sum_b;

  // Carry out is the output bit; the low byte is the residual error (wraps, no saturation).
  function automatic logic [8:0] dither_sum(input logic [7:0] c, input logic [7:0] err);
    return {1'b0, c} + {1'b0, err};
  endfunction

  // Stage 1: register inputs
  always_ff @(posedge i_pix_clk or posedge i_rst) begin
    if (i_rst) begin
      hs_p1    <= ~H_POL;
      vs_p1    <= ~V_POL;
      vld_p1   <= 1'b0;
      frame_p1 <= 1'b0;
      red_p1   <= 8'd0;
      green_p1 <= 8'd0;
      blue_p1  <= 8'd0;
    end else begin
      hs_p1    <= i_hs;
      vs_p1    <= i_vs;
      vld_p1   <= i_de;
      frame_p1 <= i_frame;
      red_p1   <= i_red;
      green_p1 <= i_green;
      blue_p1  <= i_blue;
    end
  end

`ifdef DITHER_TEMPORAL_EN
  logic [1:0] fc;

  always_ff @(posedge i_pix_clk or posedge i_rst) begin
    if (i_rst)
      fc <= 2'd0;
    else if (frame_p1)
      fc <= fc + 2'd1;
  end

  assign seed = {fc, 6'b100000};
`else
  assign seed = SEED;
`endif

  assign sum_r = dither_sum(red_p1, err_r);
  assign sum_g = dither_sum(green_p1, err_g);
  assign sum_b = dither_sum(blue_p1, err_b);

  // Stage 2: dither and register outputs; blanking reloads the accumulators
  always_ff @(posedge i_pix_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hs    <= ~H_POL;
      o_vs    <= ~V_POL;
      o_de    <= 1'b0;
      o_frame <= 1'b0;
      o_red   <= 1'b0;
      o_green <= 1'b0;
      o_blue  <= 1'b0;
      err_r   <= SEED;
      err_g   <= SEED;
      err_b   <= SEED;
    end else begin
      o_hs    <= hs_p1;
      o_vs    <= vs_p1;
      o_de    <= vld_p1;
      o_frame <= frame_p1;
      if (vld_p1) begin
        o_red   <= sum_r[8];
        o_green <= sum_g[8];
        o_blue  <= sum_b[8];
        err_r   <= sum_r[7:0];
        err_g   <= sum_g[7:0];
        err_b   <= sum_b[7:0];
      end else begin
        o_red   <= 1'b0;
        o_green <= 1'b0;
        o_blue  <= 1'b0;
        err_r   <= seed;
        err_g   <= seed;
        err_b   <= seed;
      end
    end
  end

endmodule

// File: tb/tb_dither_rgb1.sv
// Directed bench for dither_rgb1: vector table plus hand-written multi-cycle sequences.
module tb_dither_rgb1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs, vs, de, fr;
  logic [7:0] red, green, blue;
  logic       o_hs, o_vs, o_de, o_frame, o_red, o_green, o_blue;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dither_rgb1 dut (
    .i_pix_clk(clk), .i_rst(rst),
    .i_hs(hs), .i_vs(vs), .i_de(de), .i_frame(fr),
    .i_red(red), .i_green(green), .i_blue(blue),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_frame(o_frame),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue)
  );

  typedef struct {
    logic       hs, vs, de, fr;
    logic [7:0] r, g, b;
    logic       er, eg, eb;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then step past the rising edge.
  task automatic drive(input logic h, input logic v, input logic d, input logic f,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    hs = h; vs = v; de = d; fr = f; red = r; green = g; blue = b;
    @(posedge clk);
    #1;
  endtask

  task automatic blank(input int n, input logic [7:0] r);
    for (int k = 0; k < n; k++) drive(1, 1, 0, 0, r, 8'd0, 8'd0);
  endtask

  function automatic logic [6:0] outs();
    return {o_hs, o_vs, o_de, o_frame, o_red, o_green, o_blue};
  endfunction

  initial begin
    logic [7:0] line1, line2;
    int ones_r, ones_g, ones_b, nde, blank_ones;

    vecs[0]  = '{1, 1, 0, 0, 8'd200, 8'd0, 8'd0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 8'd200, 8'd0, 8'd0, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 1, 8'd0,   8'd0, 8'd0, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 0, 8'd0,   8'd0, 8'd0, 0, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 8'd0,   8'd0, 8'd0, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 8'd0,   8'd0, 8'd0, 0, 0, 0};
    vecs[6]  = '{1, 1, 0, 1, 8'd0,   8'd0, 8'd0, 0, 0, 0};
    vecs[7]  = '{1, 1, 0, 0, 8'd0,   8'd0, 8'd0, 0, 0, 0};
    for (int k = 0; k < 8; k++)
      vecs[8 + k] = '{1, 1, 1, 0, 8'd128, 8'd0, 8'd0, ~k[0], 0, 0};
    vecs[16] = '{1, 1, 0, 0, 8'd200, 8'd0, 8'd0, 0, 0, 0};
    vecs[17] = '{0, 1, 0, 0, 8'd200, 8'd0, 8'd0, 0, 0, 0};

    // Reset held with random inputs
    for (int k = 0; k < 5; k++) begin
      hs = 1'($urandom); vs = 1'($urandom); de = 1'($urandom); fr = 1'($urandom);
      red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
      @(posedge clk);
      #1;
      chk("reset_hold", 32'(outs()), 32'(7'b1100000));
    end
    #3 rst = 1'b0;
    drive(1, 1, 1, 0, 8'd255, 8'd0, 8'd0);
    chk("release_cyc1", 32'(outs()), 32'(7'b1100000));
    drive(1, 1, 0, 0, 8'd0, 8'd0, 8'd0);
    chk("release_cyc2", 32'(outs()), 32'(7'b1110100));
    blank(3, 8'd0);

    // Table: sync/frame delay and red=128 alternation
    for (int i = 0; i <= 18; i++) begin
      if (i < 18)
        drive(vecs[i].hs, vecs[i].vs, vecs[i].de, vecs[i].fr, vecs[i].r, vecs[i].g, vecs[i].b);
      else
        drive(1, 1, 0, 0, 8'd0, 8'd0, 8'd0);
      if (i >= 1)
        chk($sformatf("vec%0d", i - 1), 32'(outs()),
            32'({vecs[i-1].hs, vecs[i-1].vs, vecs[i-1].de, vecs[i-1].fr,
                 vecs[i-1].er, vecs[i-1].eg, vecs[i-1].eb}));
    end

    // 256-pixel line: blue=255, green=64, red=0
    blank(3, 8'd0);
    ones_r = 0; ones_g = 0; ones_b = 0; nde = 0;
    for (int k = 0; k < 258; k++) begin
      if (k < 256) drive(1, 1, 1, 0, 8'd0, 8'd64, 8'd255);
      else drive(1, 1, 0, 0, 8'd0, 8'd0, 8'd0);
      if (o_de) nde++;
      ones_r += int'(o_red);
      ones_g += int'(o_green);
      ones_b += int'(o_blue);
    end
    chk("line256_de", 32'(nde), 32'd256);
    chk("blue255_ones", 32'(ones_b), 32'd255);
    chk("green64_ones", 32'(ones_g), 32'd64);
    chk("red0_ones", 32'(ones_r), 32'd0);

    // Two red=200 lines separated by 160 blanking cycles carrying red=200
    blank(3, 8'd0);
    line1 = '0; line2 = '0; blank_ones = 0;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) drive(1, 1, 1, 0, 8'd200, 8'd0, 8'd0);
      else drive(1, 1, 0, 0, 8'd200, 8'd0, 8'd0);
      if (k >= 1) line1[k-1] = o_red;
    end
    for (int k = 0; k < 160; k++) begin
      drive(1, 1, 0, 0, 8'd200, 8'd0, 8'd0);
      blank_ones += int'(o_red | o_green | o_blue | o_de);
    end
    for (int k = 0; k < 9; k++) begin
      if (k < 8) drive(1, 1, 1, 0, 8'd200, 8'd0, 8'd0);
      else drive(1, 1, 0, 0, 8'd200, 8'd0, 8'd0);
      if (k >= 1) line2[k-1] = o_red;
    end
`ifndef DITHER_TEMPORAL_EN
    chk("red200_line1", 32'(line1), 32'(8'b10111011));
`endif
    chk("red200_repeat", 32'(line2), 32'(line1));
    chk("blank_zero", 32'(blank_ones), 32'd0);

    // Reset asserted mid-line, then refill
    blank(3, 8'd0);
    drive(1, 1, 1, 0, 8'd255, 8'd255, 8'd255);
    drive(1, 1, 1, 0, 8'd255, 8'd255, 8'd255);
    chk("midline_active", 32'(outs()), 32'(7'b1110111));
    #2 rst = 1'b1;
    #1 chk("midline_async", 32'(outs()), 32'(7'b1100000));
    @(posedge clk);
    #3 rst = 1'b0;
    drive(0, 0, 1, 1, 8'd255, 8'd255, 8'd255);
    chk("refill_cyc1", 32'(outs()), 32'(7'b1100000));
    drive(1, 1, 1, 0, 8'd255, 8'd255, 8'd255);
    chk("refill_cyc2", 32'(outs()), 32'(7'b0011111));
    blank(3, 8'd0);

`ifdef DITHER_TEMPORAL_EN
    // Five frames: first pixel of red=128 follows seeds 32,96,160,224,32
    rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    for (int f = 0; f < 5; f++) begin
      logic [4:0] exp_first;
      exp_first = 5'b01100;
      blank(3, 8'd0);
      drive(1, 1, 1, 0, 8'd128, 8'd0, 8'd0);
      drive(1, 1, 0, 0, 8'd0, 8'd0, 8'd0);
      chk($sformatf("temporal_f%0d", f), 32'(o_red), 32'(exp_first[f]));
      blank(2, 8'd0);
      drive(1, 1, 0, 1, 8'd0, 8'd0, 8'd0);
      blank(2, 8'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dither_rgb1.md
Name: dither_rgb1

Overview:
- Pipelined dither stage between a test card or other colour source and the 3-bit DVI Pmod pins.
- Reduces 8-bit-per-channel colour to 1 bit per channel using first-order error diffusion (sigma-delta) along each line.
- Delays sync, display-enable and frame-start signals so they stay aligned with the dithered colour.
- Replaces plain MSB truncation so mid-level colours and gradients show as pixel density, not hard bands.

Parameters:
- H_POL, 0, horizontal sync active level; sets the reset/idle value of o_hs.
- V_POL, 0, vertical sync active level; sets the reset/idle value of o_vs.
- SEED, 128, 8-bit error-accumulator value loaded during blanking.

Ports:
- i_pix_clk  in   1  pixel clock; all state on rising edge
- i_rst      in   1  asynchronous, active-high reset
- i_hs       in   1  horizontal sync from display timings
- i_vs       in   1  vertical sync from display timings
- i_de       in   1  display enable from display timings
- i_frame    in   1  frame-start pulse, one cycle wide
- i_red      in   8  red colour, same cycle as i_de
- i_green    in   8  green colour
- i_blue     in   8  blue colour
- o_hs       out  1  i_hs delayed 2 cycles
- o_vs       out  1  i_vs delayed 2 cycles
- o_de       out  1  i_de delayed 2 cycles
- o_frame    out  1  i_frame delayed 2 cycles
- o_red      out  1  dithered red
- o_green    out  1  dithered green
- o_blue     out  1  dithered blue

Behaviour:
- Reset is asynchronous on i_rst high and synchronous on release.
- Reset values:
  - o_hs = ~H_POL, o_vs = ~V_POL.
  - o_de, o_frame, o_red, o_green, o_blue = 0.
  - All pipeline registers cleared; sync registers in stage 1 take the inactive level.
  - Error accumulators = SEED.
  - Frame counter (optional feature) = 0.
- Pipeline and latency:
  - Stage 1 registers all inputs.
  - Stage 2 computes the dither and registers all outputs.
  - Fixed 2-cycle latency for every output; no stalls, no handshake.
  - Input pixel at cycle N appears on outputs at cycle N+2.
- Per-channel arithmetic (identical for R, G, B; independent accumulators err_r, err_g, err_b):
  - sum = {1'b0, c} + {1'b0, err}, 9 bits, where c is the stage-1 colour.
  - When stage-1 de = 1: output bit = sum[8]; err <= sum[7:0].
  - When stage-1 de = 0: output bit = 0; err <= seed, where seed = SEED, or the temporal seed when the optional feature is enabled.
- Effects of the accumulator reload:
  - Every line and the vertical blanking start from the seed value.
  - No error carries across lines.
- Colour outputs are 0 whenever o_de = 0, including during reset.
- Boundary conditions:
  - c = 0: output always 0.
  - c = 255: output 0 at most once per 256 pixels.
  - c = 128 with seed 128: output alternates 1,0,1,0 starting with 1.
- Wrap-around: sum[7:0] discards the carry; no saturation logic is needed.
- Reset mid-line: outputs go to reset values immediately. After release, the first 2 cycles output reset values, then the pipeline refills.

Optional Feature:
- Macro: DITHER_TEMPORAL_EN.
- With it defined:
  - A 2-bit frame counter increments on each stage-1 frame pulse and wraps 3 to 0.
  - seed = {fc, 6'b100000}, i.e. 32, 96, 160, 224 for fc = 0..3.
  - This rotates the pattern phase each frame and suppresses vertical stripe artefacts.
- Without it: no counter exists and seed = SEED constantly.

Test Plan:
- Hold i_rst=1 with random inputs -> o_hs=1, o_vs=1 (pol 0), o_de=0, rgb=0. Release; the first valid output appears exactly 2 cycles after the first de=1 input.
- de=1 for 8 pixels, red=128, SEED=128 -> o_red sequence 1,0,1,0,1,0,1,0; o_green=o_blue=0 when those inputs are 0.
- Line of 256 pixels with blue=255 -> exactly 255 ones on o_blue. Line of 256 pixels with green=64 -> exactly 64 ones.
- Two lines of red=200 separated by 160 blanking cycles -> second line output identical to the first, proving the seed reload. Outputs are 0 throughout blanking even though red=200.
- Toggle i_hs, i_vs and i_frame with distinct patterns -> each reproduced on its output delayed exactly 2 cycles.
- With DITHER_TEMPORAL_EN: four frames of red=128 -> first-pixel o_red per frame follows seeds 32,96,160,224, giving 0,0,1,1; fifth frame repeats frame 1.
